// File: rtl/cfg_chain_pkg.sv
// -----------------------------------------------------------------------------
// cfg_chain_pkg
// Shared definitions for the configuration-chain loader:
//   - cfg_state_t   : loader FSM states (IDLE, LOAD, SHIFT, DONE)
//   - cnt_w()       : width of a counter able to hold 0..chain_len
//   - DEF_CHAIN_LEN / DEF_WORD_W : default chain length and input word width
// -----------------------------------------------------------------------------
package cfg_chain_pkg;

  localparam int DEF_CHAIN_LEN = 512;
  localparam int DEF_WORD_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } cfg_state_t;

  // Bit-counter width: must represent the terminal value chain_len itself.
  function automatic int cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/cfg_chain_readback.sv
// -----------------------------------------------------------------------------
// cfg_chain_readback
// Collects the bits falling out of the chain tail while the chain shifts and
// presents them as WORD_W-wide words, LSB = first sample. A final short group
// is zero-padded in its upper bits. rb_valid pulses for one cycle, the cycle
// after the last sample of a group. No backpressure.
// Only instantiated when CFG_CHAIN_READBACK_EN is defined.
//
// Ports:
//   prog_clk     in   clock (rising edge)
//   pReset       in   asynchronous active-high reset
//   sample_en    in   chain shifts this cycle; sample sample_bit
//   sample_last  in   this sample is the final bit of the load
//   sample_bit   in   chain tail bit
//   rb_data      out  last completed readback word
//   rb_valid     out  one-cycle pulse when rb_data is updated
// -----------------------------------------------------------------------------
module cfg_chain_readback #(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              sample_en,
  input  logic              sample_last,
  input  logic              sample_bit,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int              IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] group_reg, group_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [WORD_W-1:0] rb_data_reg;
  logic              rb_valid_reg;
  logic              group_close;

  // Starting a fresh group clears the upper bits, so a short final group
  // comes out zero-padded without any extra shifting.
  always_comb begin
    group_next          = (idx_reg == '0) ? '0 : group_reg;
    group_next[idx_reg] = sample_bit;
  end

  assign group_close = (idx_reg == IDX_LAST) || sample_last;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      group_reg    <= '0;
      idx_reg      <= '0;
      rb_data_reg  <= '0;
      rb_valid_reg <= 1'b0;
    end else begin
      rb_valid_reg <= 1'b0;
      if (sample_en) begin
        group_reg <= group_next;
        if (group_close) begin
          rb_data_reg  <= group_next;
          rb_valid_reg <= 1'b1;
          idx_reg      <= '0;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
    end
  end

  assign rb_data  = rb_data_reg;
  assign rb_valid = rb_valid_reg;

endmodule

// File: rtl/cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// cfg_chain_loader
// Accepts configuration words on a valid/ready stream and serializes them,
// LSB first, one bit per prog_clk cycle onto the fabric configuration chain.
// Stops after exactly CHAIN_LEN bits (dropping unused upper bits of a final
// partial word) and pulses done.
//
// Optional feature macro: CFG_CHAIN_READBACK_EN
//   When defined, adds rb_data/rb_valid and captures ccff_tail on every shift
//   cycle (previous chain contents) via cfg_chain_readback.
//
// Ports:
//   prog_clk       in   clock (rising edge)
//   pReset         in   asynchronous active-high reset
//   start          in   begin a load (only honoured in IDLE)
//   in_data        in   configuration word, LSB shifted first
//   in_valid       in   in_data valid
//   in_ready       out  word accepted this cycle when in_valid is high
//   ccff_head      out  serial bit into chain head (registered)
//   ccff_shift_en  out  chain shifts on next edge (registered)
//   ccff_tail      in   serial bit from chain tail (readback only)
//   busy           out  high while not IDLE
//   done           out  one-cycle completion pulse
//   rb_data        out  readback word        (CFG_CHAIN_READBACK_EN only)
//   rb_valid       out  readback word strobe (CFG_CHAIN_READBACK_EN only)
//   bit_count      out  bits shifted so far in the current load
// -----------------------------------------------------------------------------
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic                         prog_clk,
  input  logic                         pReset,
  input  logic                         start,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         ccff_head,
  output logic                         ccff_shift_en,
  input  logic                         ccff_tail,
  output logic                         busy,
  output logic                         done,
`ifdef CFG_CHAIN_READBACK_EN
  output logic [WORD_W-1:0]            rb_data,
  output logic                         rb_valid,
`endif
  output logic [cnt_w(CHAIN_LEN)-1:0]  bit_count
);

  localparam int               CNT_W    = cnt_w(CHAIN_LEN);
  localparam int               IDX_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  cfg_state_t        state_reg, state_next;
  logic [WORD_W-1:0] shift_reg, shift_next;   // bits of the word not yet on ccff_head
  logic [IDX_W-1:0]  idx_reg, idx_next;       // position within the word of the bit on ccff_head
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              head_reg, head_next;
  logic              shift_en_reg, shift_en_next;

  logic last_bit;   // this cycle carries chain bit CHAIN_LEN-1
  logic word_end;   // this cycle carries the top bit of the current word
  logic accept;

  assign last_bit = (state_reg == ST_SHIFT) && (count_reg == CNT_LAST);
  assign word_end = (state_reg == ST_SHIFT) && (idx_reg == IDX_LAST);

  // Ready also goes high on the top bit of a non-final word so the next word
  // follows with no bubble.
  assign in_ready = (state_reg == ST_LOAD) || (word_end && !last_bit);
  assign accept   = in_ready && in_valid;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      idx_reg      <= '0;
      count_reg    <= '0;
      head_reg     <= 1'b0;
      shift_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      idx_reg      <= idx_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      shift_en_reg <= shift_en_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    idx_next      = idx_reg;
    count_next    = count_reg;
    head_next     = head_reg;     // head holds through stalls
    shift_en_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD;
          count_next = '0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          state_next    = ST_SHIFT;
          head_next     = in_data[0];
          shift_next    = in_data >> 1;
          idx_next      = '0;
          shift_en_next = 1'b1;
        end
      end

      ST_SHIFT: begin
        count_next = count_reg + 1'b1;
        if (last_bit) begin
          // Chain full; any remaining bits of this word are dropped.
          state_next = ST_DONE;
        end else if (word_end) begin
          if (accept) begin
            head_next     = in_data[0];
            shift_next    = in_data >> 1;
            idx_next      = '0;
            shift_en_next = 1'b1;
          end else begin
            state_next = ST_LOAD;
          end
        end else begin
          head_next     = shift_reg[0];
          shift_next    = shift_reg >> 1;
          idx_next      = idx_reg + 1'b1;
          shift_en_next = 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign ccff_head     = head_reg;
  assign ccff_shift_en = shift_en_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = (state_reg == ST_DONE);
  assign bit_count     = count_reg;

`ifdef CFG_CHAIN_READBACK_EN
  cfg_chain_readback #(
    .WORD_W (WORD_W)
  ) u_readback (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .sample_en   (shift_en_reg),
    .sample_last (last_bit),
    .sample_bit  (ccff_tail),
    .rb_data     (rb_data),
    .rb_valid    (rb_valid)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
module tb_cfg_chain_loader;
  import cfg_chain_pkg::*;

  localparam int CL    = 20;
  localparam int W     = 8;
  localparam int CNT_W = cnt_w(CL);
  localparam int NW    = (CL + W - 1) / W;   // words needed per load

  logic prog_clk = 1'b0;
  logic pReset;
  logic start, in_valid;
  logic [W-1:0] in_data;
  logic in_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done;
  logic [CNT_W-1:0] bit_count;
`ifdef CFG_CHAIN_READBACK_EN
  logic [W-1:0] rb_data;
  logic rb_valid;
  logic [W-1:0] rb_data1;
  logic rb_valid1;
`endif

  // Second instance: single-flop chain
  logic start1, in_valid1;
  logic [W-1:0] in_data1;
  logic in_ready1, head1, shift_en1, tail1, busy1, done1;
  logic [0:0] bit_count1;

  always #5 prog_clk = ~prog_clk;

  cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
`ifdef CFG_CHAIN_READBACK_EN
    .rb_data(rb_data), .rb_valid(rb_valid),
`endif
    .bit_count(bit_count)
  );

  cfg_chain_loader #(.CHAIN_LEN(1), .WORD_W(W)) dut1 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start1), .in_data(in_data1),
    .in_valid(in_valid1), .in_ready(in_ready1), .ccff_head(head1),
    .ccff_shift_en(shift_en1), .ccff_tail(tail1), .busy(busy1), .done(done1),
`ifdef CFG_CHAIN_READBACK_EN
    .rb_data(rb_data1), .rb_valid(rb_valid1),
`endif
    .bit_count(bit_count1)
  );

  // Behavioural fabric chains: index 0 sits next to the head.
  logic [CL-1:0] chain;
  logic chain1;
  logic preload_ones;
  always @(posedge prog_clk) begin
    if (preload_ones) begin
      chain  <= '1;
      chain1 <= 1'b1;
    end else begin
      if (ccff_shift_en === 1'b1) chain <= {chain[CL-2:0], ccff_head};
      if (shift_en1 === 1'b1) chain1 <= head1;
    end
  end
  assign ccff_tail = chain[CL-1];
  assign tail1     = chain1;

  int edge_n = 0;
  always @(posedge prog_clk) edge_n <= edge_n + 1;

  // Per-cycle recorder, sampled mid-cycle
  bit logging = 1'b0;
  logic rec_en[$];
  logic rec_head[$];
  logic rec_done[$];
  logic [CNT_W-1:0] rec_bc[$];
  logic [W-1:0] rb_q[$];
  always @(negedge prog_clk) begin
    if (logging) begin
      rec_en.push_back(ccff_shift_en);
      rec_head.push_back(ccff_head);
      rec_done.push_back(done);
      rec_bc.push_back(bit_count);
`ifdef CFG_CHAIN_READBACK_EN
      if (rb_valid === 1'b1) rb_q.push_back(rb_data);
`endif
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stimulus description for one load
  logic [W-1:0] words[$];
  int stalls[$];          // ready-but-not-valid cycles before each word
  int restart_after = -1; // cycle offset of a spurious start pulse
  int start_edge, done_edge, consumed, load_no = 0;
  logic [CL-1:0] snap;

  function automatic logic ref_bit(input int k);
    logic [W-1:0] wv;
    wv = words[k / W];
    return wv[k % W];
  endfunction

  function automatic logic [W-1:0] ref_rb(input int g);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++)
      if (g * W + j < CL) r[j] = snap[CL - 1 - (g * W + j)];
    return r;
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 0);
    check({name, "_head"}, 32'(ccff_head), 0);
    check({name, "_shift_en"}, 32'(ccff_shift_en), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_done"}, 32'(done), 0);
    check({name, "_bit_count"}, 32'(bit_count), 0);
`ifdef CFG_CHAIN_READBACK_EN
    check({name, "_rb_valid"}, 32'(rb_valid), 0);
    check({name, "_rb_data"}, 32'(rb_data), 0);
`endif
  endtask

  // Entered at posedge+1 with the loader idle.
  task automatic run_load();
    int w, stall_left;
    bit seen_done;
    rec_en.delete(); rec_head.delete(); rec_done.delete(); rec_bc.delete(); rb_q.delete();
    snap = chain;
    load_no++;
    logging = 1'b1;
    start = 1'b1;
    start_edge = edge_n + 1;
    in_valid = 1'b0;
    w = 0;
    stall_left = stalls[0];
    seen_done = 1'b0;
    done_edge = -1;
    for (int cyc = 0; cyc < 4 * CL + 100 && !seen_done; cyc++) begin
      @(negedge prog_clk);
      if (done === 1'b1) begin
        seen_done = 1'b1;
        done_edge = edge_n + 1;
      end
      if (in_valid && in_ready === 1'b1) begin
        $display("load %0d: word %0d accepted = %02h", load_no, w, in_data);
        w++;
        stall_left = (w < words.size()) ? stalls[w] : 0;
      end else if (in_ready === 1'b1 && !in_valid && stall_left > 0) begin
        stall_left--;
      end
      @(posedge prog_clk); #1;
      start    = (restart_after >= 0) && (cyc + 1 == restart_after);
      in_valid = (w < words.size()) && (stall_left == 0);
      in_data  = (w < words.size()) ? words[w] : W'($urandom);
    end
    start = 1'b0;
    in_valid = 1'b0;
    consumed = w;
    if (!seen_done) check("done_timeout", 0, 1);
    repeat (3) @(negedge prog_clk);
    logging = 1'b0;
    @(posedge prog_clk); #1;
  endtask

  task automatic check_load(input string name);
    int n_sh, first, last, k, held_bad, n_done, done_idx, dec, bubbles_exp, lat_extra;
    n_sh = 0; first = -1; last = -1; held_bad = 0; n_done = 0; done_idx = -1; dec = 0;
    bubbles_exp = 0; lat_extra = 0;
    for (int i = 0; i < NW; i++) begin
      lat_extra += stalls[i];
      if (i > 0) bubbles_exp += stalls[i];
    end
    foreach (rec_en[i]) begin
      if (rec_en[i] === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        n_sh++;
      end
      if (rec_done[i] === 1'b1) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
      end
    end
    check({name, "_shifts"}, n_sh, CL);
    check({name, "_bubbles"}, (last - first + 1) - n_sh, bubbles_exp);
    k = 0;
    foreach (rec_en[i]) begin
      if (rec_en[i] === 1'b1) begin
        if (k < CL) check($sformatf("%s_bit%0d", name, k), 32'(rec_head[i]), 32'(ref_bit(k)));
        k++;
      end
    end
    for (int i = first + 1; i <= last; i++) begin
      if (rec_en[i] !== 1'b1 && rec_head[i] !== rec_head[i-1]) held_bad++;
      if (rec_bc[i] < rec_bc[i-1]) dec++;
    end
    check({name, "_head_held"}, held_bad, 0);
    check({name, "_bc_monotonic"}, dec, 0);
    if (first >= 0) check({name, "_bc_first"}, 32'(rec_bc[first]), 0);
    check({name, "_done_pulses"}, n_done, 1);
    check({name, "_latency"}, done_edge - start_edge, CL + 2 + lat_extra);
    if (done_idx >= 0) check({name, "_bc_at_done"}, 32'(rec_bc[done_idx]), CL);
    check({name, "_consumed"}, consumed, NW);
    check({name, "_idle_ready"}, 32'(in_ready), 0);
    check({name, "_idle_busy"}, 32'(busy), 0);
`ifdef CFG_CHAIN_READBACK_EN
    check({name, "_rb_count"}, rb_q.size(), NW);
    for (int g = 0; g < NW && g < rb_q.size(); g++)
      check($sformatf("%s_rb%0d", name, g), 32'(rb_q[g]), 32'(ref_rb(g)));
`endif
  endtask

  task automatic set_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] w2, input logic [W-1:0] w3);
    words.delete();
    words.push_back(w0); words.push_back(w1); words.push_back(w2); words.push_back(w3);
    stalls.delete();
    repeat (4) stalls.push_back(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int packed_bits, k, n1, d1, s1;
    logic h1;
    logic [0:0] bc1;
    pReset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
    preload_ones = 1'b1;
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    check_reset_outputs("reset");
    check("reset_dut1_busy", 32'(busy1), 0);
    @(posedge prog_clk); #1;
    preload_ones = 1'b0;
    pReset = 1'b0;
    repeat (2) @(posedge prog_clk); #1;

    // Directed stream, no stalls
    set_words(8'hA5, 8'h3C, 8'h0F, 8'h77);
    run_load();
    check_load("basic");
    packed_bits = 0; k = 0;
    foreach (rec_en[i]) if (rec_en[i] === 1'b1) begin
      if (rec_head[i] === 1'b1 && k < 32) packed_bits |= (1 << k);
      k++;
    end
    check("basic_stream", packed_bits, 32'hF3CA5);

    // Three-cycle stall before the second word
    set_words(8'hA5, 8'h3C, 8'h0F, 8'h77);
    stalls[1] = 3;
    run_load();
    check_load("stall");

    // Spurious start mid-shift
    set_words(8'hA5, 8'h3C, 8'h0F, 8'h77);
    restart_after = 6;
    run_load();
    restart_after = -1;
    check_load("restart");

    // Reset at bit 10
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h5A;
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 60 && !hit; c++) begin
        @(negedge prog_clk);
        if (bit_count === CNT_W'(10)) hit = 1'b1;
        else begin
          @(posedge prog_clk); #1;
          start = 1'b0;
          in_data = W'($urandom);
        end
      end
      check("reset_bit10_reached", 32'(hit), 1);
    end
    pReset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    in_valid = 1'b0;
    @(posedge prog_clk); #1;
    pReset = 1'b0;
    @(posedge prog_clk); #1;
    set_words(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    run_load();
    check_load("after_reset");

    // Randomized loads
    for (int r = 0; r < 4; r++) begin
      words.delete(); stalls.delete();
      for (int i = 0; i <= NW; i++) begin
        words.push_back(W'($urandom));
        stalls.push_back(int'($urandom_range(0, 3)));
      end
      run_load();
      check_load($sformatf("rand%0d", r));
    end

`ifdef CFG_CHAIN_READBACK_EN
    // Readback of an all-ones chain, then of the zeros just written
    preload_ones = 1'b1;
    @(posedge prog_clk); #1;
    preload_ones = 1'b0;
    set_words(8'h00, 8'h00, 8'h00, 8'h00);
    run_load();
    check_load("rb_ones");
    check("rb_ones_cnt", rb_q.size(), 3);
    if (rb_q.size() == 3) begin
      check("rb_ones_w0", 32'(rb_q[0]), 32'hFF);
      check("rb_ones_w1", 32'(rb_q[1]), 32'hFF);
      check("rb_ones_w2", 32'(rb_q[2]), 32'h0F);
    end
    set_words(8'h00, 8'h00, 8'h00, 8'h00);
    run_load();
    check_load("rb_zeros");
    check("rb_zeros_cnt", rb_q.size(), 3);
    if (rb_q.size() == 3) begin
      check("rb_zeros_w0", 32'(rb_q[0]), 0);
      check("rb_zeros_w1", 32'(rb_q[1]), 0);
      check("rb_zeros_w2", 32'(rb_q[2]), 0);
    end
`endif

    // Single-flop chain
    start1 = 1'b1; in_valid1 = 1'b1; in_data1 = 8'h01;
    s1 = edge_n + 1;
    n1 = 0; h1 = 1'b0; d1 = -1; bc1 = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge prog_clk);
      if (shift_en1 === 1'b1) begin n1++; h1 = head1; end
      if (done1 === 1'b1 && d1 < 0) begin d1 = edge_n + 1; bc1 = bit_count1; end
      @(posedge prog_clk); #1;
      start1 = 1'b0;
    end
    in_valid1 = 1'b0;
    $display("chain1 load: shifts=%0d head=%0b done_after=%0d", n1, h1, d1 - s1);
    check("len1_shifts", n1, 1);
    check("len1_head", 32'(h1), 1);
    check("len1_latency", d1 - s1, 3);
    check("len1_bit_count", 32'(bc1), 1);
    check("len1_idle_busy", 32'(busy1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
